// File: rtl/axilite_pkg.sv
// Shared widths and FSM state encodings for the AXI-Lite slave and its timers.
package axilite_pkg;

  localparam int AXIL_AW = 32;
  localparam int AXIL_DW = 32;
  localparam int AXIL_SW = 4;

  typedef enum logic [1:0] {
    WR_COLLECT = 2'd0,
    WR_ISSUE   = 2'd1,
    WR_WAIT    = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_RESP  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axilite_slave_timer.sv
// Saturating backend-wait timer: cleared on clr_i, counts while en_i, flags expiry
// once TIMEOUT_CYC enabled cycles have elapsed. TIMEOUT_CYC=0 never expires.
module axilite_slave_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      assign expired_o = en_i && (cnt_q >= CW'(TIMEOUT_CYC));
    end
  endgenerate

endmodule

// File: rtl/axilite_slave.sv
// AXI-Lite responder (AW/W/AR/R, no B) turning each access into a single backend
// start/done request; write and read paths run independently.
module axilite_slave
  import axilite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic               axi_awvalid,
  input  logic [AXIL_AW-1:0] axi_awaddr,
  output logic               axi_awready,
  input  logic               axi_wvalid,
  input  logic [AXIL_DW-1:0] axi_wdata,
  input  logic [AXIL_SW-1:0] axi_wstrb,
  output logic               axi_wready,
  input  logic               axi_arvalid,
  input  logic [AXIL_AW-1:0] axi_araddr,
  output logic               axi_arready,
  output logic               axi_rvalid,
  output logic [AXIL_DW-1:0] axi_rdata,
  input  logic               axi_rready,
  output logic               bk_wstart,
  output logic [AXIL_AW-1:0] bk_waddr,
  output logic [AXIL_DW-1:0] bk_wdata,
  output logic [AXIL_SW-1:0] bk_wstrb,
  input  logic               bk_wdone,
  output logic               bk_rstart,
  output logic [AXIL_AW-1:0] bk_raddr,
  input  logic [AXIL_DW-1:0] bk_rdata,
  input  logic               bk_rdone,
  output logic               timeout_err
);

  // Holds all readies low while in reset and for the first cycle after release.
  logic live_q;

  wr_state_t          wr_state_q, wr_state_d;
  logic               aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [AXIL_AW-1:0] awaddr_q, awaddr_d;
  logic [AXIL_DW-1:0] wdata_q, wdata_d;
  logic [AXIL_SW-1:0] wstrb_q, wstrb_d;
  logic [AXIL_AW-1:0] bk_waddr_q, bk_waddr_d;
  logic [AXIL_DW-1:0] bk_wdata_q, bk_wdata_d;
  logic [AXIL_SW-1:0] bk_wstrb_q, bk_wstrb_d;

  rd_state_t          rd_state_q, rd_state_d;
  logic [AXIL_AW-1:0] bk_raddr_q, bk_raddr_d;
  logic [AXIL_DW-1:0] rdata_q, rdata_d;

  logic wr_exp, rd_exp, wr_to, rd_to;
  logic aw_hs, w_hs, ar_hs;

  assign axi_awready = live_q && (wr_state_q == WR_COLLECT) && !aw_got_q;
  assign axi_wready  = live_q && (wr_state_q == WR_COLLECT) && !w_got_q;
  assign axi_arready = live_q && (rd_state_q == RD_IDLE);
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign ar_hs       = axi_arvalid && axi_arready;

  assign bk_wstart   = (wr_state_q == WR_ISSUE);
  assign bk_waddr    = bk_waddr_q;
  assign bk_wdata    = bk_wdata_q;
  assign bk_wstrb    = bk_wstrb_q;
  assign bk_rstart   = (rd_state_q == RD_ISSUE);
  assign bk_raddr    = bk_raddr_q;
  assign axi_rvalid  = (rd_state_q == RD_RESP);
  assign axi_rdata   = (rd_state_q == RD_RESP) ? rdata_q : '0;

  // A done arriving on the expiry cycle wins over the timeout.
  assign wr_to       = (wr_state_q == WR_WAIT) && wr_exp && !bk_wdone;
  assign rd_to       = (rd_state_q == RD_WAIT) && rd_exp && !bk_rdone;
  assign timeout_err = wr_to || rd_to;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bk_waddr_d = bk_waddr_q;
    bk_wdata_d = bk_wdata_q;
    bk_wstrb_d = bk_wstrb_q;
    case (wr_state_q)
      WR_COLLECT: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = axi_awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
        end
        // Backend fields only move when a new request is launched.
        if (aw_got_d && w_got_d) begin
          wr_state_d = WR_ISSUE;
          bk_waddr_d = awaddr_d;
          bk_wdata_d = wdata_d;
          bk_wstrb_d = wstrb_d;
        end
      end
      WR_ISSUE: begin
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        wr_state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (bk_wdone || wr_exp) begin
          wr_state_d = WR_COLLECT;
        end
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    bk_raddr_d = bk_raddr_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          bk_raddr_d = axi_araddr;
          rd_state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: rd_state_d = RD_WAIT;
      RD_WAIT: begin
        if (bk_rdone) begin
          rdata_d    = bk_rdata;
          rd_state_d = RD_RESP;
        end else if (rd_exp) begin
          rdata_d    = TIMEOUT_RDATA;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi_rready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      live_q     <= 1'b0;
      wr_state_q <= WR_COLLECT;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bk_waddr_q <= '0;
      bk_wdata_q <= '0;
      bk_wstrb_q <= '0;
      rd_state_q <= RD_IDLE;
      bk_raddr_q <= '0;
      rdata_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bk_waddr_q <= bk_waddr_d;
      bk_wdata_q <= bk_wdata_d;
      bk_wstrb_q <= bk_wstrb_d;
      rd_state_q <= rd_state_d;
      bk_raddr_q <= bk_raddr_d;
      rdata_q    <= rdata_d;
    end
  end

  axilite_slave_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wr_timer (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .clr_i     (wr_state_q == WR_ISSUE),
    .en_i      (wr_state_q == WR_WAIT),
    .expired_o (wr_exp)
  );

  axilite_slave_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rd_timer (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .clr_i     (rd_state_q == RD_ISSUE),
    .en_i      (rd_state_q == RD_WAIT),
    .expired_o (rd_exp)
  );

endmodule
